downlink_pwm_decoder: RTL and testbench

- Receive-side companion to the backscatter modulator.
- Decodes the reader's downlink from the envelope-detector output DEC_IN, using pulse-width coding: each high pulse is one bit, and its width selects 0 or 1.
- Assembles bits MSB-first into bytes and flags frame end after a long low gap.
- Runs on the same 20 MHz (50 ns) CLK as the modulator; feeds the tag control logic.

---
 rtl/downlink_pwm_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_downlink_pwm_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/downlink_pwm_decoder.sv
// -----------------------------------------------------------------------------
// downlink_pwm_decoder
//
// Decodes the reader's pulse-width coded downlink from the envelope detector.
// Each high pulse on DEC_IN carries one bit, and the width of the pulse selects
// the bit value:
//   width <  MIN_PULSE              glitch, dropped
//   MIN_PULSE <= width <= BIT0_MAX  bit 0
//   BIT0_MAX  <  width <= BIT1_MAX  bit 1
//   width >  BIT1_MAX               error: ERR strobe, frame discarded
// Bits are assembled MSB-first into bytes. A low gap of GAP_END cycles ends
// the frame.
//
// Ports:
//   CLK         system clock (20 MHz)
//   RSTN        synchronous active-low reset
//   EN          block enable; low clears everything, like reset
//   DEC_IN      envelope detector output (asynchronous, high = carrier pulse)
//   DATA        last completed byte, MSB = first received bit
//   DATA_VALID  one-cycle strobe, DATA has just been updated
//   FRAME_DONE  one-cycle strobe at frame end
//   BIT_COUNT   bits in the last frame (saturating at 255), updated with
//               FRAME_DONE and held afterwards
//   ERR         one-cycle strobe, overlong pulse
//   BUSY        high whenever the decoder is not idle
//   DBG_STATE   current FSM state (IDLE=0, HIGH=1, LOW=2, ERROR=3)
//
// Output semantics: the block only produces strobes. It has no backpressure.
// DATA_VALID, FRAME_DONE and ERR are each high for exactly one cycle. The
// consumer must capture DATA with DATA_VALID, and BIT_COUNT with FRAME_DONE,
// in that same cycle.
// -----------------------------------------------------------------------------
module downlink_pwm_decoder #(
  parameter int MIN_PULSE = 20,
  parameter int BIT0_MAX  = 200,
  parameter int BIT1_MAX  = 400,
  parameter int GAP_END   = 800
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       DEC_IN,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAME_DONE,
  output logic [7:0] BIT_COUNT,
  output logic       ERR,
  output logic       BUSY,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [15:0] MIN_W   = 16'(MIN_PULSE);
  localparam logic [15:0] BIT0_W  = 16'(BIT0_MAX);
  localparam logic [15:0] BIT1_W  = 16'(BIT1_MAX);
  localparam logic [15:0] GAP_W_1 = 16'(GAP_END - 1);

  state_t      state_q, state_d;
  logic        sync_1_q;
  logic        s_q;          // synchronised DEC_IN level
  logic        s_prev_q;     // s_q one cycle later, used for edge detection
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  frame_bits_q, frame_bits_d;
  logic [2:0]  byte_pos_q, byte_pos_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  bit_count_q, bit_count_d;
  logic        dv_q, dv_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;

  logic        rise;
  logic        fall;
  logic        new_bit;
  logic [7:0]  shifted;
  logic [15:0] cnt_inc;

  assign rise    = s_q & ~s_prev_q;
  assign fall    = ~s_q & s_prev_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // The pulse that just ended is a 1 when it was wider than BIT0_MAX.
  assign new_bit = (cnt_q > BIT0_W);
  assign shifted = {shreg_q[6:0], new_bit};

  // cnt_q counts the cycles that s_prev_q has spent at its current level.
  // In the cycle where an edge is seen, it therefore holds the full width of
  // the level that just ended. While a level continues, "cnt_q == N-1" means
  // that the current cycle is the N-th cycle at that level.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (s_q != s_prev_q) ? 16'd1 : cnt_inc;
    frame_bits_d = frame_bits_q;
    byte_pos_d   = byte_pos_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    bit_count_d  = bit_count_q;
    dv_d         = 1'b0;
    fd_d         = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (rise) begin
          state_d      = ST_HIGH;
          cnt_d        = 16'd1;
          frame_bits_d = 8'd0;
          byte_pos_d   = 3'd0;
          shreg_d      = 8'd0;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          if (cnt_q >= MIN_W) begin
            shreg_d      = shifted;
            frame_bits_d = (frame_bits_q == 8'hFF) ? frame_bits_q : frame_bits_q + 8'd1;
            byte_pos_d   = byte_pos_q + 3'd1;
            if (byte_pos_q == 3'd7) begin
              data_d = shifted;
              dv_d   = 1'b1;
            end
          end
        end else if (s_q && (cnt_q == BIT1_W)) begin
          // This cycle is high cycle BIT1_MAX+1. Abort without waiting for
          // the falling edge.
          state_d      = ST_ERROR;
          err_d        = 1'b1;
          frame_bits_d = 8'd0;
          byte_pos_d   = 3'd0;
          shreg_d      = 8'd0;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (!s_q && (cnt_q == GAP_W_1)) begin
          state_d = ST_IDLE;
          if (frame_bits_q != 8'd0) begin
            fd_d        = 1'b1;
            bit_count_d = frame_bits_q;
          end
        end
      end

      ST_ERROR: begin
        // Pulses are ignored. Any high level restarts the gap count, because
        // cnt_q is reset on every edge.
        if (!s_q && !s_prev_q && (cnt_q == GAP_W_1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN || !EN) begin
      state_q      <= ST_IDLE;
      sync_1_q     <= 1'b0;
      s_q          <= 1'b0;
      s_prev_q     <= 1'b0;
      cnt_q        <= 16'd0;
      frame_bits_q <= 8'd0;
      byte_pos_q   <= 3'd0;
      shreg_q      <= 8'd0;
      data_q       <= 8'd0;
      bit_count_q  <= 8'd0;
      dv_q         <= 1'b0;
      fd_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_1_q     <= DEC_IN;
      s_q          <= sync_1_q;
      s_prev_q     <= s_q;
      cnt_q        <= cnt_d;
      frame_bits_q <= frame_bits_d;
      byte_pos_q   <= byte_pos_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      bit_count_q  <= bit_count_d;
      dv_q         <= dv_d;
      fd_q         <= fd_d;
      err_q        <= err_d;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = dv_q;
  assign FRAME_DONE = fd_q;
  assign BIT_COUNT  = bit_count_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_downlink_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_downlink_pwm_decoder
//
// Drives pulse trains on DEC_IN. A pulse-level reference model predicts every
// strobe: its kind, its value and the cycle at which it must appear. Each
// prediction is pushed into exp_q. A monitor pops one prediction for each
// strobe that the DUT produces and compares the two.
//
// Expected timing, counted in CLK cycles from the negedge that changes DEC_IN:
//   DATA_VALID  falling edge + 3
//   FRAME_DONE  falling edge + GAP_END + 2
//   ERR         rising edge  + BIT1_MAX + 3
// -----------------------------------------------------------------------------
module tb_downlink_pwm_decoder;

  localparam int MIN_PULSE = 20;
  localparam int BIT0_MAX  = 200;
  localparam int BIT1_MAX  = 400;
  localparam int GAP_END   = 800;
  localparam int EW        = 42;   // {kind[1:0], value[7:0], cycle[31:0]}

  localparam logic [1:0] K_DV  = 2'd1;
  localparam logic [1:0] K_FD  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       EN = 1'b1;
  logic       DEC_IN = 1'b0;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       FRAME_DONE;
  logic [7:0] BIT_COUNT;
  logic       ERR;
  logic       BUSY;
  logic [1:0] DBG_STATE;

  always #25 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  downlink_pwm_decoder #(
    .MIN_PULSE(MIN_PULSE),
    .BIT0_MAX (BIT0_MAX),
    .BIT1_MAX (BIT1_MAX),
    .GAP_END  (GAP_END)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .EN        (EN),
    .DEC_IN    (DEC_IN),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .FRAME_DONE(FRAME_DONE),
    .BIT_COUNT (BIT_COUNT),
    .ERR       (ERR),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic got_event(input logic [1:0] kind, input logic [7:0] val);
    logic [EW-1:0] act;
    logic [EW-1:0] req;
    act = {kind, val, 32'(cyc)};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_strobe: got kind=%0d val=0x%02h cyc=%0d, expected no strobe",
               kind, val, cyc);
    end else begin
      req = exp_q.pop_front();
      if (act !== req) begin
        n_fail++;
        $display("FAIL strobe: got kind=%0d val=0x%02h cyc=%0d, expected kind=%0d val=0x%02h cyc=%0d",
                 act[41:40], act[39:32], act[31:0], req[41:40], req[39:32], req[31:0]);
      end
    end
  endtask

  // Monitor: DUT outputs are sampled on the falling edge.
  always @(negedge CLK) begin
    if (DATA_VALID) got_event(K_DV, DATA);
    if (FRAME_DONE) got_event(K_FD, BIT_COUNT);
    if (ERR)        got_event(K_ERR, 8'h00);
  end

  // ---------------- reference model + drivers ----------------
  int frame_bits[$];   // bits received so far in the current frame
  bit in_err = 1'b0;

  task automatic model_clear();
    frame_bits.delete();
    in_err = 1'b0;
  endtask

  task automatic idle(input int n);
    DEC_IN = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // One high pulse of width w, followed by a low gap of the given length.
  task automatic pulse(input int w, input int gap);
    int t_rise;
    int t_fall;
    int b8;
    int n;
    t_rise = cyc;
    if (!in_err && w > BIT1_MAX) begin
      exp_q.push_back({K_ERR, 8'h00, 32'(t_rise + BIT1_MAX + 3)});
      in_err = 1'b1;
      frame_bits.delete();
    end
    DEC_IN = 1'b1;
    repeat (w) @(negedge CLK);
    t_fall = cyc;
    DEC_IN = 1'b0;
    if (!in_err && w >= MIN_PULSE) begin
      frame_bits.push_back((w > BIT0_MAX) ? 1 : 0);
      n = frame_bits.size();
      if (n % 8 == 0) begin
        b8 = 0;
        for (int i = 0; i < 8; i++) b8 = b8 * 2 + frame_bits[n - 8 + i];
        exp_q.push_back({K_DV, 8'(b8), 32'(t_fall + 3)});
      end
    end
    if (gap >= GAP_END) begin
      if (!in_err && frame_bits.size() > 0) begin
        n = (frame_bits.size() > 255) ? 255 : frame_bits.size();
        exp_q.push_back({K_FD, 8'(n), 32'(t_fall + GAP_END + 2)});
      end
      model_clear();
    end
    repeat (gap) @(negedge CLK);
  endtask

  function automatic int rand_width(input int b);
    return b ? $urandom_range(201, 400) : $urandom_range(20, 200);
  endfunction

  task automatic send_byte(input logic [7:0] v, input int last_gap);
    logic [7:0] r;
    r = v;
    for (int i = 7; i >= 0; i--) pulse(rand_width(r[i]), (i == 0) ? last_gap : 100);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"},      32'(DATA), 32'h0);
    check({tag, "_bit_count"}, 32'(BIT_COUNT), 32'h0);
    check({tag, "_busy"},      32'(BUSY), 32'h0);
    check({tag, "_strobes"},   {29'h0, DATA_VALID, FRAME_DONE, ERR}, 32'h0);
  endtask

  initial begin
    #(95000 * 50);
    $display("FAIL watchdog: simulation did not complete, expected completion within 95000 cycles");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    int k;

    // Reset state
    repeat (3) @(negedge CLK);
    check_cleared("reset");
    RSTN = 1'b1;
    idle(20);

    // Frame 1 0 1 0 0 1 0 1 with fixed widths gives 0xA5 and 8 bits.
    begin
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 7; i >= 0; i--) pulse(pat[i] ? 300 : 100, (i == 0) ? 1000 : 100);
    end
    check("a5_data", 32'(DATA), 32'hA5);
    check("a5_bit_count", 32'(BIT_COUNT), 32'd8);
    check("a5_busy", 32'(BUSY), 32'h0);

    // Boundary widths. 19 is dropped. 20, 200, 201, 400 decode as 0, 0, 1, 1.
    // Five 0-bits follow. The first byte is 0011_0000 and the 9th bit is
    // discarded, but it is still counted.
    pulse(19, 100);
    pulse(20, 100);
    pulse(200, 100);
    pulse(201, 100);
    pulse(400, 100);
    for (int i = 0; i < 5; i++) pulse(100, (i == 4) ? 1000 : 100);
    check("bnd_data", 32'(DATA), 32'h30);
    check("bnd_bit_count", 32'(BIT_COUNT), 32'd9);

    // Overlong pulse after 3 bits. The following pulse is ignored, and there
    // is no FRAME_DONE.
    pulse(100, 100);
    pulse(300, 100);
    pulse(100, 100);
    pulse(401, 100);
    check("err_busy", 32'(BUSY), 32'h1);
    check("err_state", 32'(DBG_STATE), 32'd3);
    pulse(100, 1000);
    check("err_exit_busy", 32'(BUSY), 32'h0);
    check("err_data_kept", 32'(DATA), 32'h30);

    // 12 bits. A 799-cycle gap in the middle does not end the frame. An
    // exact 800-cycle gap does end it.
    for (int i = 0; i < 12; i++)
      pulse(rand_width($urandom_range(0, 1)), (i == 5) ? 799 : ((i == 11) ? 800 : 100));
    idle(200);
    check("gap_bit_count", 32'(BIT_COUNT), 32'd12);
    check("gap_busy", 32'(BUSY), 32'h0);

    // Reset in the middle of the 5th pulse. The next clean frame must decode.
    for (int i = 0; i < 4; i++) pulse(rand_width($urandom_range(0, 1)), 100);
    DEC_IN = 1'b1;
    repeat (50) @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    DEC_IN = 1'b0;
    model_clear();
    check_cleared("rst_mid");
    idle(100);
    rb = 8'($urandom_range(0, 255));
    send_byte(rb, 1000);
    check("rst_next_data", 32'(DATA), 32'(rb));
    check("rst_next_bit_count", 32'(BIT_COUNT), 32'd8);

    // EN low during a frame clears everything. While EN stays low, DEC_IN
    // activity produces nothing.
    for (int i = 0; i < 5; i++) pulse(rand_width($urandom_range(0, 1)), 100);
    DEC_IN = 1'b1;
    repeat (60) @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    model_clear();
    check_cleared("en_low");
    for (int i = 0; i < 8; i++) begin
      DEC_IN = 1'b1;
      repeat ($urandom_range(20, 450)) @(negedge CLK);
      DEC_IN = 1'b0;
      repeat ($urandom_range(2, 900)) @(negedge CLK);
    end
    check_cleared("en_held");
    EN = 1'b1;
    idle(20);
    rb = 8'($urandom_range(0, 255));
    send_byte(rb, 1000);
    check("en_next_data", 32'(DATA), 32'(rb));

    // Random pulse train: glitches, bit 0s, bit 1s, errors and short or long gaps.
    for (int i = 0; i < 50; i++) begin
      int w;
      int g;
      k = $urandom_range(0, 9);
      if (k == 0)      w = $urandom_range(1, 19);
      else if (k == 1) w = $urandom_range(401, 440);
      else if (k <= 5) w = $urandom_range(20, 200);
      else             w = $urandom_range(201, 400);
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(800, 900) : $urandom_range(2, 300);
      if (i == 49) g = 1000;
      pulse(w, g);
    end

    idle(20);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(BUSY), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
